// File: rtl/wb_shared_bus_arb.sv
// rtl/wb_shared_bus_arb.sv - Wishbone shared-bus interconnect, round-robin arbitration, address-field decode
// Define WB_SHARED_BUS_TIMEOUT_EN to error-terminate transactions that see no ack within TIMEOUT BUSY cycles.
module wb_shared_bus_arb #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 8,
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int SEL_LO      = 28,
  parameter int TIMEOUT     = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  output logic [DW-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic                        s_we_o,
  output logic [NUM_SLAVES-1:0]       s_stb_o,
  input  logic [NUM_SLAVES*DW-1:0]    s_dat_i,
  input  logic [NUM_SLAVES-1:0]       s_ack_i,
  output logic [NUM_MASTERS-1:0]      grant_o,
  output logic                        busy_o
);

  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [SW:0] NS_LIM = (SW+1)'(NUM_SLAVES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [MW-1:0] g_q, g_d, last_q, last_d;
  logic [MW-1:0] pick, cand;
  logic          found;
  logic [AW-1:0] adr_g;
  logic [SW-1:0] idx;
  logic          mapped, stb_g, timeout_hit;

  assign adr_g  = m_adr_i[g_q*AW +: AW];
  assign stb_g  = m_stb_i[g_q];
  assign mapped = ({1'b0, idx} < NS_LIM);

  // A single slave has no select field: everything maps to slave 0.
  if (NUM_SLAVES > 1) begin : g_dec
    assign idx = adr_g[SEL_LO +: SW];
  end else begin : g_dec_single
    assign idx = '0;
  end

`ifdef WB_SHARED_BUS_TIMEOUT_EN
  logic [15:0] timer_q;

  // Held at zero in IDLE so every BUSY entry starts a fresh count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)              timer_q <= '0;
    else if (state_q == IDLE) timer_q <= '0;
    else                      timer_q <= timer_q + 16'd1;
  end

  assign timeout_hit = (timer_q == 16'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Round-robin search starting just after the last master served.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    cand  = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = MW'((int'(last_q) + i) % NUM_MASTERS);
      if (!found && m_stb_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      g_q     <= '0;
      last_q  <= MW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    m_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_stb_o = '0;
    grant_o = '0;
    busy_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          g_d     = pick;
        end
      end
      BUSY: begin
        busy_o       = 1'b1;
        grant_o[g_q] = 1'b1;
        s_adr_o      = adr_g;
        s_dat_o      = m_dat_i[g_q*DW +: DW];
        s_sel_o      = m_sel_i[g_q*(DW/8) +: DW/8];
        s_we_o       = m_we_i[g_q];
        if (mapped) m_dat_o = s_dat_i[idx*DW +: DW];
        if (mapped && stb_g && !timeout_hit) s_stb_o[idx] = 1'b1;
        state_d = IDLE;
        last_d  = g_q;
        if (!stb_g) begin
          // abort: silent return to IDLE
        end else if (!mapped) begin
          m_err_o[g_q] = 1'b1;
        end else if (s_ack_i[idx]) begin
          m_ack_o[g_q] = 1'b1;
        end else if (timeout_hit) begin
          m_err_o[g_q] = 1'b1;
        end else begin
          state_d = BUSY;
          last_d  = last_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_shared_bus_arb.sv
// tb/tb_wb_shared_bus_arb.sv - directed and randomized checks of wb_shared_bus_arb against a transaction model
module tb_wb_shared_bus_arb;

  localparam int NM = 3;
  localparam int NS = 6;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SEL_LO = 28;
  localparam int TMO = 4;
`ifdef WB_SHARED_BUS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NM*AW-1:0]  m_adr_i;
  logic [NM*DW-1:0]  m_dat_i;
  logic [NM*DW/8-1:0] m_sel_i;
  logic [NM-1:0]     m_we_i, m_stb_i;
  logic [DW-1:0]     m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, grant_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [DW/8-1:0]   s_sel_o;
  logic              s_we_o, busy_o;
  logic [NS-1:0]     s_stb_o, s_ack_i;
  logic [NS*DW-1:0]  s_dat_i;

  int checks = 0;
  int errors = 0;

  bit            mb;
  int            mg, mlast, mtimer;
  logic [NM-1:0] ev_ack, ev_err, pend;

  always #5 clk = ~clk;

  wb_shared_bus_arb #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .DW(DW), .AW(AW), .SEL_LO(SEL_LO), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i), .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o), .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mb = 1'b0; mg = 0; mlast = NM - 1; mtimer = 0;
  endtask

  task automatic set_m(input int k, input logic stb, input logic [AW-1:0] adr);
    m_stb_i[k] = stb;
    m_adr_i[k*AW +: AW] = adr;
  endtask

  task automatic rand_fill();
    for (int k = 0; k < NM; k++) begin
      m_dat_i[k*DW +: DW] = $urandom;
      m_sel_i[k*4 +: 4] = 4'($urandom);
      m_we_i[k] = 1'($urandom);
    end
    for (int s = 0; s < NS; s++) s_dat_i[s*DW +: DW] = $urandom;
  endtask

  // Compare one cycle against the model, advance the model, then move to just after the next edge.
  task automatic tick();
    logic [NS-1:0] e_stb;
    logic [NM-1:0] e_ack, e_err, e_gnt;
    int idx;
    bit mapped, stbg, tmo, done;
    #2;
    e_stb = '0; e_ack = '0; e_err = '0; e_gnt = '0;
    if (!mb) begin
      chk("idle_busy", busy_o, 0);
      chk("idle_stb", s_stb_o, 0);
      chk("idle_ack", m_ack_o, 0);
      chk("idle_err", m_err_o, 0);
      for (int k = 1; k <= NM; k++)
        if (!mb && m_stb_i[(mlast + k) % NM]) begin
          mb = 1'b1; mg = (mlast + k) % NM; mtimer = 0;
        end
    end else begin
      idx    = int'(m_adr_i[mg*AW + SEL_LO +: 3]);
      mapped = idx < NS;
      stbg   = m_stb_i[mg];
      tmo    = TMO_EN && (mtimer == TMO - 1);
      if (mapped && stbg && !tmo) e_stb[idx] = 1'b1;
      e_gnt[mg] = 1'b1;
      chk("busy", busy_o, 1);
      chk("grant", grant_o, e_gnt);
      chk("s_adr", s_adr_o, m_adr_i[mg*AW +: AW]);
      chk("s_dat", s_dat_o, m_dat_i[mg*DW +: DW]);
      chk("s_sel", s_sel_o, m_sel_i[mg*4 +: 4]);
      chk("s_we", s_we_o, m_we_i[mg]);
      chk("s_stb", s_stb_o, e_stb);
      if (mapped) chk("m_dat", m_dat_o, s_dat_i[idx*DW +: DW]);
      done = 1'b1;
      if (!stbg) begin
      end else if (!mapped) e_err[mg] = 1'b1;
      else if (s_ack_i[idx]) e_ack[mg] = 1'b1;
      else if (tmo) e_err[mg] = 1'b1;
      else begin
        done = 1'b0;
        mtimer++;
      end
      chk("m_ack", m_ack_o, e_ack);
      chk("m_err", m_err_o, e_err);
      if (done) begin
        mb = 1'b0; mlast = mg;
      end
    end
    ev_ack = e_ack;
    ev_err = e_err;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0; m_stb_i = '0;
    s_dat_i = '0; s_ack_i = '0;
    ev_ack = '0; ev_err = '0; pend = '0;
    model_reset();
    do_reset();

    // reset state
    #2;
    chk("rst_stb", s_stb_o, 0); chk("rst_ack", m_ack_o, 0); chk("rst_err", m_err_o, 0);
    chk("rst_grant", grant_o, 0); chk("rst_busy", busy_o, 0); chk("rst_adr", s_adr_o, 0);
    chk("rst_mdat", m_dat_o, 0);

    // single read from slave 1
    rand_fill();
    set_m(0, 1'b1, 32'h1000_0040);
    s_dat_i[1*DW +: DW] = 32'hDEAD_BEEF;
    s_ack_i = 6'b000010;
    chk("rd_idle_grant", grant_o, 0);
    tick();
    #2;
    chk("rd_grant", grant_o, 3'b001); chk("rd_ack", m_ack_o, 3'b001);
    chk("rd_data", m_dat_o, 32'hDEAD_BEEF); chk("rd_stb", s_stb_o, 6'b000010);
    tick();
    set_m(0, 1'b0, 32'h1000_0040);
    tick();

    // round robin M0/M1, every slave acks
    do_reset();
    s_ack_i = '1;
    set_m(0, 1'b1, 32'h0000_0100);
    set_m(1, 1'b1, 32'h3000_0200);
    for (int i = 0; i < 8; i++) begin
      rand_fill();
      if (i % 2 == 1) begin
        #2;
        chk("rr_grant", grant_o, ((i / 2) % 2 == 1) ? 3'b010 : 3'b001);
      end
      tick();
    end
    set_m(0, 1'b0, 32'h0); set_m(1, 1'b0, 32'h0);
    tick(); tick();

    // unmapped select value 7
    set_m(1, 1'b1, 32'h7000_0000);
    tick();
    #2;
    chk("um_stb", s_stb_o, 0); chk("um_err", m_err_o, 3'b010); chk("um_ack", m_ack_o, 0);
    tick();
    set_m(1, 1'b0, 32'h7000_0000);
    #2;
    chk("um_idle_busy", busy_o, 0); chk("um_idle_err", m_err_o, 0);
    tick();

    // silent slave 2
    s_ack_i = '0;
    set_m(0, 1'b1, 32'h2000_0000);
    tick();
`ifdef WB_SHARED_BUS_TIMEOUT_EN
    for (int b = 1; b <= 4; b++) begin
      #2;
      if (b < 4) begin
        chk("to_wait_err", m_err_o, 0); chk("to_wait_stb", s_stb_o, 6'b000100);
      end else begin
        chk("to_err", m_err_o, 3'b001); chk("to_stb", s_stb_o, 0);
      end
      tick();
    end
    set_m(0, 1'b0, 32'h2000_0000);
    tick();
`else
    for (int b = 0; b < 120; b++) begin
      #2;
      chk("hang_busy", busy_o, 1);
      tick();
    end
    set_m(0, 1'b0, 32'h2000_0000);
    tick(); tick();
`endif

    // abort by M0 while M1 waits
    do_reset();
    s_ack_i = '0;
    set_m(0, 1'b1, 32'h3000_0000);
    set_m(1, 1'b1, 32'h1000_0000);
    tick(); tick(); tick();
    set_m(0, 1'b0, 32'h3000_0000);
    #2;
    chk("ab_busy", busy_o, 1); chk("ab_ack", m_ack_o, 0); chk("ab_err", m_err_o, 0);
    tick();
    #2;
    chk("ab_idle", busy_o, 0);
    tick();
    #2;
    chk("ab_next_grant", grant_o, 3'b010);
    tick();
    set_m(1, 1'b0, 32'h1000_0000);
    tick(); tick();

    // async reset in the middle of BUSY
    set_m(0, 1'b1, 32'h3000_0000);
    tick();
    #2;
    chk("ar_pre_busy", busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_stb", s_stb_o, 0); chk("ar_ack", m_ack_o, 0); chk("ar_err", m_err_o, 0);
    chk("ar_grant", grant_o, 0); chk("ar_busy", busy_o, 0); chk("ar_adr", s_adr_o, 0);
    chk("ar_dat", s_dat_o, 0); chk("ar_sel", s_sel_o, 0); chk("ar_we", s_we_o, 0);
    chk("ar_mdat", m_dat_o, 0);
    model_reset();
    set_m(0, 1'b1, 32'h1000_0000);
    set_m(1, 1'b1, 32'h2000_0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    #2;
    chk("ar_first_grant", grant_o, 3'b001);
    tick();
    m_stb_i = '0;
    tick(); tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NM; k++) begin
        if (pend[k] && $urandom_range(0, 15) == 0) pend[k] = 1'b0;
        else if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1;
          m_adr_i[k*AW +: AW] = $urandom;
        end
        m_stb_i[k] = pend[k];
      end
      rand_fill();
      s_ack_i = NS'($urandom);
      tick();
      pend = pend & ~(ev_ack | ev_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_shared_bus_arb.md
Name: wb_shared_bus_arb

Overview:
- Parametrised Wishbone shared-bus interconnect: NUM_MASTERS masters, NUM_SLAVES slaves, round-robin arbitration and address-field slave decode.
- Next generation of the fixed 2-master/8-slave bus between the multi-cycle CPU and the memory/MIO/PS2 slaves.
- Adds error termination for unmapped addresses and for slaves that never acknowledge.
- One transaction in flight at a time.

Parameters:
- NUM_MASTERS, 2, number of master ports (1..8)
- NUM_SLAVES, 8, number of slave ports (1..16)
- DW, 32, data width
- AW, 32, address width
- SEL_LO, 28, LSB of the slave-select address field; field width SW = clog2(NUM_SLAVES), bits [SEL_LO+SW-1:SEL_LO]
- TIMEOUT, 255, cycles in BUSY without ack before error (2..65535)

Ports:
- clk_i  in  1  bus clock
- rst_ni  in  1  reset, asynchronous, active-low
- m_adr_i  in  NUM_MASTERS*AW  master addresses, master k in slice k
- m_dat_i  in  NUM_MASTERS*DW  master write data
- m_sel_i  in  NUM_MASTERS*DW/8  byte selects
- m_we_i  in  NUM_MASTERS  write enables
- m_stb_i  in  NUM_MASTERS  strobes
- m_dat_o  out  DW  read data, broadcast to all masters
- m_ack_o  out  NUM_MASTERS  per-master acknowledge
- m_err_o  out  NUM_MASTERS  per-master error
- s_adr_o  out  AW  broadcast address
- s_dat_o  out  DW  broadcast write data
- s_sel_o  out  DW/8  broadcast byte selects
- s_we_o  out  1  broadcast write enable
- s_stb_o  out  NUM_SLAVES  one-hot slave strobe
- s_dat_i  in  NUM_SLAVES*DW  slave read data
- s_ack_i  in  NUM_SLAVES  slave acknowledges
- grant_o  out  NUM_MASTERS  one-hot current grant (debug/GPIO)
- busy_o  out  1  high in BUSY

Behaviour:
- Reset (rst_ni low, async): state=IDLE, grant=0, last=NUM_MASTERS-1, timer=0.
  - All outputs 0: s_stb_o, m_ack_o, m_err_o, grant_o, busy_o.
  - s_adr_o, s_dat_o, s_sel_o, s_we_o and m_dat_o are also 0.
- FSM, registered state. Transitions evaluated at the rising edge of clk_i.
- IDLE:
  - If any m_stb_i is high, grant the first requester searching last+1, last+2, ... modulo NUM_MASTERS.
  - grant registered, go to BUSY. Arbitration latency is 1 cycle; no slave strobe in IDLE.
- BUSY, combinational routing:
  - s_adr_o/s_dat_o/s_sel_o/s_we_o follow the granted master.
  - idx = adr field of the granted master.
  - s_stb_o[idx] = m_stb_i[g] when idx < NUM_SLAVES.
  - m_dat_o = s_dat_i slice idx.
- BUSY exit conditions, in priority order:
  1. Granted master drops stb (abort) → IDLE. No ack/err; last=g.
  2. idx >= NUM_SLAVES (unmapped) → m_err_o[g]=1 for this cycle, no slave strobed, → IDLE, last=g.
  3. s_ack_i[idx]=1 → m_ack_o[g]=1 in the same cycle (combinational pass-through), → IDLE, last=g.
  4. timer == TIMEOUT-1 → m_err_o[g]=1, s_stb_o deasserted that cycle, → IDLE, last=g.
  5. Otherwise timer++ and stay in BUSY. timer clears on entry to BUSY.
- ack/err are only ever driven to the granted master. Ungranted masters see 0.
- A master still holding stb after ack re-arbitrates in IDLE. Other requesters win first under round robin.
- Minimum transaction: 1 cycle arbitration plus 1 BUSY cycle with an immediate ack. Back-to-back throughput is one transfer per 2 cycles.
- s_ack_i from non-addressed slaves is ignored.
- Address bits outside the select field pass unchanged to the slave.
- Reset mid-transaction: immediate return to IDLE with all strobes low. No ack or err is generated.

Optional Feature:
- Macro WB_SHARED_BUS_TIMEOUT_EN.
- Defined: timer and timeout error as in exit condition 4.
- Undefined: no timer logic. BUSY waits indefinitely for ack or abort; TIMEOUT is unused. Unmapped-address error remains.

Test Plan:
- Single read: M0 stb, adr=0x1000_0040 (slave 1), slave 1 acks on first BUSY cycle with 0xDEADBEEF → grant_o=01 one cycle after stb; m_ack_o=01 and m_dat_o=0xDEADBEEF in the same cycle; other s_stb_o bits 0.
- Round robin: M0 and M1 stb continuously, all slaves ack immediately → grants alternate 01,10,01,10. After reset the first grant is M0.
- Unmapped: NUM_SLAVES=6, M1 adr=0x7000_0000 → s_stb_o=0; m_err_o=10 for exactly one cycle in BUSY; bus returns to IDLE.
- Timeout (macro defined, TIMEOUT=4): slave 2 never acks → m_err_o[g] pulses on the 4th BUSY cycle; s_stb_o[2] is low that cycle. Without the macro busy_o stays high for 100+ cycles.
- Abort: M0 drops stb after 2 BUSY cycles → IDLE next edge, no ack/err, and M1's pending request is granted next.
- Async reset: assert rst_ni low mid-BUSY between clock edges → all outputs 0 immediately. After release, the first grant goes to M0.
